async_receiver: RTL and testbench
=================================

# async_receiver

Serial UART receive stage, the counterpart to the codebase's async transmitter: it deserialises an 8N1 frame from the RxD line (LSB first, one start bit, one stop bit, no parity) into a parallel byte. RxD is sampled with a free-running oversampling tick, filtered, and framed by a state machine. Each good byte is presented with a one-cycle valid pulse. The block sits between the board pin (or a transmitter in loopback) and the byte-consuming logic.

## Interface
- ClkFrequency, 50000000: clock frequency in Hz.
- Baud, 115200: line bit rate.
- Oversampling, 8: ticks per bit; power of two, 4..16.
- BaudGeneratorAccWidth, 16: width of the tick accumulator.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- RxD  input  1  asynchronous serial line, idle high.
- RxD_data  output  8  last correctly framed byte; holds until the next good byte.
- RxD_data_ready  output  1  one-cycle pulse when RxD_data is updated.
- RxD_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- RxD_busy  output  1  high whenever the FSM is not in IDLE.
- RxD_idle, RxD_endofpacket  output  1 each  present only with ASYNC_RX_IDLE_DETECT_EN.

## Operation
- **Tick generator**
  - Accumulator is BaudGeneratorAccWidth+1 bits and runs continuously.
  - Update: acc <= acc[W-1:0] + Inc, where Inc = round(Baud·Oversampling·2^W / ClkFrequency).
  - Tick = acc[W], which gives a one-clk pulse at Baud·Oversampling.
- **Synchroniser:** 2 flops on RxD, reset to 1.
- **Filter:** 2-bit saturating counter, updated on ticks only.
  - Counts down on sync=0 and up on sync=1.
  - rx_bit goes to 0 at count 0 and to 1 at count 3; otherwise it holds.
  - Reset values: count=3, rx_bit=1.
- **Bit-timing counter:** log2(Oversampling) bits. It is cleared on every state entry and increments on ticks.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_bit=0 → START.
  - START: on the tick where the counter reaches Oversampling/2−1, rx_bit=0 → DATA (bit index 0). Otherwise → IDLE (false start).
  - DATA: every Oversampling ticks, sample rx_bit into shift[7], shift right, and increment the bit index. After the 8th sample → STOP.
  - STOP: after Oversampling ticks, sample the stop bit.
    - Stop = 1: load RxD_data from shift, pulse RxD_data_ready, → IDLE.
    - Stop = 0: pulse RxD_frame_err, leave RxD_data unchanged, → BREAK.
  - BREAK: wait for rx_bit=1, then → IDLE. A held-low line therefore never starts a new frame.
- **Reset values:** RxD_data=0x00, RxD_data_ready=0, RxD_frame_err=0, RxD_busy=0, state=IDLE, shift=0.
- **Reset mid-frame:** the partial byte is discarded and no pulse is produced. The next start edge is received normally.
- **Back-to-back frames:** a start bit that immediately follows the stop bit must be received. The FSM is in IDLE before the start bit's filtered falling edge.

## Timing
- Sampling points: data bits are sampled 1.5, 2.5 … 8.5 bit times after the filtered start edge; the stop bit at 9.5.
- Filtered edge lag behind RxD: 2 clk (synchroniser) plus 2–3 ticks (filter).
- RxD_data_ready latency: asserts the clk after the stop-bit sampling tick, with RxD_data valid in that same cycle. Total ≈ 9.5 bit times + edge lag after the RxD start edge.
- Pulse exclusivity: RxD_data_ready and RxD_frame_err are never high together and are always exactly one cycle wide.
- Baud tolerance: ±3 % mismatch must still yield correct bytes.

## Configuration
- ASYNC_RX_IDLE_DETECT_EN defined:
  - A 7-bit gap counter clears on any rx_bit=0.
  - It increments on ticks while the FSM is in IDLE, saturating at 10·Oversampling.
  - RxD_idle is high while saturated. Reset value: 1.
  - RxD_endofpacket pulses for one cycle when saturation is first reached after at least one received byte (good or errored).
- ASYNC_RX_IDLE_DETECT_EN undefined: both ports and the counter are absent.

## Structure
- Package async_rx_pkg holds:
  - the FSM state encodings;
  - the Inc computation as a constant function of (ClkFrequency, Baud, Oversampling, W).
- Sub-module baud_tick_gen holds the accumulator and tick output. It is reusable by the transmitter with Oversampling=1.

## Test plan
- Byte 0x55 sent at 115200 → RxD_data=0x55; RxD_data_ready pulses exactly once; RxD_frame_err stays 0.
- 0xA3 followed immediately by 0x00 (no idle gap) → two ready pulses, carrying 0xA3 then 0x00.
- 1-clk low glitch on an idle line → no ready pulse, no frame error; FSM returns to IDLE.
- Frame 0x3C with the stop bit low, then the line held low for 20 bit times → one RxD_frame_err pulse; RxD_data keeps its previous value; no further pulses until the line returns high.
- rst_n asserted at data bit 4, then 0x81 sent → outputs at reset values during reset; afterwards RxD_data=0x81.
- With ASYNC_RX_IDLE_DETECT_EN defined, byte 0x7E followed by idle → one RxD_endofpacket pulse 10 bit times after its stop bit, and RxD_idle=1.

Source files
------------

// File: rtl/async_rx_pkg.sv
// rtl/async_rx_pkg.sv - shared types and constants for the UART receive stage
// Contents:
//   rx_state_e - receiver FSM state encodings
//   baud_inc   - accumulator increment for a baud tick generator

package async_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   // round(baud * ovs * 2^acc_w / clk_hz), done in 64-bit so the shift
   // cannot overflow for any sensible accumulator width.
   function automatic int baud_inc(input int clk_hz, input int baud,
                                   input int ovs, input int acc_w);
      longint num;
      num = (longint'(baud) * longint'(ovs)) << acc_w;
      return int'((num + longint'(clk_hz) / 2) / longint'(clk_hz));
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional accumulator producing a Baud*Oversampling tick
// Ports:
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   tick  out  one-clk pulse at Baud*Oversampling Hz (free running)

module baud_tick_gen
   import async_rx_pkg::*;
#(
   parameter int ClkFrequency = 50000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 8,
   parameter int AccWidth     = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int                INC_I = baud_inc(ClkFrequency, Baud, Oversampling, AccWidth);
   localparam logic [AccWidth:0] INC   = INC_I[AccWidth:0];

   logic [AccWidth:0] acc_q, acc_d;

   // The carry out of the low W bits is the tick; it is dropped on the
   // next add so each overflow yields exactly one pulse.
   always_comb begin
      acc_d = {1'b0, acc_q[AccWidth-1:0]} + INC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign tick = acc_q[AccWidth];

endmodule

// File: rtl/async_receiver.sv
// rtl/async_receiver.sv - 8N1 UART receiver with oversampled, filtered framing
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   RxD             in   asynchronous serial line, idle high
//   RxD_data        out  last correctly framed byte
//   RxD_data_ready  out  one-cycle pulse when RxD_data updates
//   RxD_frame_err   out  one-cycle pulse when the stop bit is low
//   RxD_busy        out  high whenever the FSM is not idle
//   RxD_idle        out  line idle for 10 bit times (ASYNC_RX_IDLE_DETECT_EN)
//   RxD_endofpacket out  pulse when idle is first reached after a byte (ASYNC_RX_IDLE_DETECT_EN)

module async_receiver
   import async_rx_pkg::*;
#(
   parameter int ClkFrequency          = 50000000,
   parameter int Baud                  = 115200,
   parameter int Oversampling          = 8,
   parameter int BaudGeneratorAccWidth = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_frame_err,
   output logic       RxD_busy
`ifdef ASYNC_RX_IDLE_DETECT_EN
   ,
   output logic       RxD_idle,
   output logic       RxD_endofpacket
`endif
);

   localparam int               CNT_W    = $clog2(Oversampling);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(Oversampling / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Oversampling - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic tick;

   baud_tick_gen #(
      .ClkFrequency (ClkFrequency),
      .Baud         (Baud),
      .Oversampling (Oversampling),
      .AccWidth     (BaudGeneratorAccWidth)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       filt_cnt_q, filt_cnt_d;
   logic             rx_bit_q, rx_bit_d;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             sample_tick;

   // Synchroniser and glitch filter. rx_bit follows the new counter value
   // so a clean edge is seen three ticks after it leaves the synchroniser.
   always_comb begin
      sync1_d    = RxD;
      sync2_d    = sync1_q;
      filt_cnt_d = filt_cnt_q;
      rx_bit_d   = rx_bit_q;
      if (tick) begin
         if (!sync2_q && filt_cnt_q != 2'd0) begin
            filt_cnt_d = filt_cnt_q - 2'd1;
         end else if (sync2_q && filt_cnt_q != 2'd3) begin
            filt_cnt_d = filt_cnt_q + 2'd1;
         end
         if (filt_cnt_d == 2'd0) begin
            rx_bit_d = 1'b0;
         end else if (filt_cnt_d == 2'd3) begin
            rx_bit_d = 1'b1;
         end
      end
   end

   // Bit-centre tick in DATA/STOP: the counter wraps every Oversampling ticks.
   assign sample_tick = tick && (bit_cnt_q == CNT_LAST);

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      ready_d   = 1'b0;
      ferr_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            bit_idx_d = 3'd0;
            if (!rx_bit_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            // Half a bit after the edge: still low means a real start bit.
            if (tick && bit_cnt_q == CNT_HALF) begin
               state_d = rx_bit_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (sample_tick) begin
               shift_d   = {rx_bit_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (sample_tick) begin
               if (rx_bit_q) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // A line held low must go high before another frame can start.
            if (rx_bit_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      if (state_d != state_q) begin
         bit_cnt_d = '0;
      end else if (tick) begin
         bit_cnt_d = bit_cnt_q + CNT_ONE;
      end else begin
         bit_cnt_d = bit_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         filt_cnt_q <= 2'd3;
         rx_bit_q   <= 1'b1;
         bit_cnt_q  <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         ready_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_cnt_q <= filt_cnt_d;
         rx_bit_q   <= rx_bit_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         ferr_q     <= ferr_d;
      end
   end

   assign RxD_data       = data_q;
   assign RxD_data_ready = ready_q;
   assign RxD_frame_err  = ferr_q;
   assign RxD_busy       = (state_q != ST_IDLE);

`ifdef ASYNC_RX_IDLE_DETECT_EN
   localparam int             GAP_MAX_I = 10 * Oversampling;
   localparam int             GAP_W     = ($clog2(GAP_MAX_I + 1) > 7) ? $clog2(GAP_MAX_I + 1) : 7;
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_MAX_I);
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   logic [GAP_W-1:0] gap_q, gap_d;
   logic             seen_q, seen_d;
   logic             eop_q, eop_d;

   // seen remembers that a byte (good or errored) ended since the last
   // end-of-packet, so a long idle after reset does not report a packet.
   always_comb begin
      gap_d  = gap_q;
      seen_d = seen_q | ready_q | ferr_q;
      eop_d  = 1'b0;
      if (!rx_bit_q) begin
         gap_d = '0;
      end else if (tick && state_q == ST_IDLE && gap_q != GAP_MAX) begin
         gap_d = gap_q + GAP_ONE;
      end
      if (gap_d == GAP_MAX && gap_q != GAP_MAX && seen_d) begin
         eop_d  = 1'b1;
         seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q  <= GAP_MAX;
         seen_q <= 1'b0;
         eop_q  <= 1'b0;
      end else begin
         gap_q  <= gap_d;
         seen_q <= seen_d;
         eop_q  <= eop_d;
      end
   end

   assign RxD_idle        = (gap_q == GAP_MAX);
   assign RxD_endofpacket = eop_q;
`endif

endmodule

// File: tb/tb_async_receiver.sv
// tb/tb_async_receiver.sv - self-checking bench for async_receiver

module tb_async_receiver;

   localparam int BIT_CLKS = 434;   // 50 MHz / 115200

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RxD = 1'b1;
   logic [7:0] RxD_data;
   logic       RxD_data_ready;
   logic       RxD_frame_err;
   logic       RxD_busy;
`ifdef ASYNC_RX_IDLE_DETECT_EN
   logic       RxD_idle;
   logic       RxD_endofpacket;
`endif

   async_receiver #(
      .ClkFrequency          (50000000),
      .Baud                  (115200),
      .Oversampling          (8),
      .BaudGeneratorAccWidth (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .RxD             (RxD),
      .RxD_data        (RxD_data),
      .RxD_data_ready  (RxD_data_ready),
      .RxD_frame_err   (RxD_frame_err),
      .RxD_busy        (RxD_busy)
`ifdef ASYNC_RX_IDLE_DETECT_EN
      ,
      .RxD_idle        (RxD_idle),
      .RxD_endofpacket (RxD_endofpacket)
`endif
   );

   always #10 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         n_ready = 0;
   int         n_ferr = 0;
   int         n_overlap = 0;
   int         n_wide = 0;
   int         n_eop = 0;
   longint     cyc = 0;
   longint     eop_cyc = 0;
   logic       prev_ready = 1'b0;
   logic       prev_ferr = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: records every received byte and pulse-shape violations.
   always @(negedge clk) begin
      if (RxD_data_ready === 1'b1) begin
         got_q.push_back(RxD_data);
         n_ready = n_ready + 1;
      end
      if (RxD_frame_err === 1'b1) n_ferr = n_ferr + 1;
      if (RxD_data_ready === 1'b1 && RxD_frame_err === 1'b1) n_overlap = n_overlap + 1;
      if ((RxD_data_ready === 1'b1 && prev_ready === 1'b1) ||
          (RxD_frame_err === 1'b1 && prev_ferr === 1'b1)) n_wide = n_wide + 1;
      prev_ready = RxD_data_ready;
      prev_ferr  = RxD_frame_err;
`ifdef ASYNC_RX_IDLE_DETECT_EN
      if (RxD_endofpacket === 1'b1) begin
         n_eop   = n_eop + 1;
         eop_cyc = cyc;
      end
`endif
   end

   task automatic drive_bit(input logic v, input int bc);
      RxD = v;
      repeat (bc) @(negedge clk);
   endtask

   // Start bit, 8 data bits LSB first, stop bit; the line is left at stop_v.
   task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v);
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
      drive_bit(stop_v, bc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      RxD   = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (RxD_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h expected 00", RxD_data); end
      total++; if (RxD_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", RxD_data_ready); end
      total++; if (RxD_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", RxD_frame_err); end
      total++; if (RxD_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", RxD_busy); end
      rst_n = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int r0, f0;
      r0 = n_ready; f0 = n_ferr;
      send_frame(8'h55, BIT_CLKS, 1'b1);
      last_good = 8'h55;
      repeat (BIT_CLKS) @(negedge clk);
      total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL single_count: got %0d expected 1", n_ready - r0); end
      total++; if (got_q[r0] !== 8'h55) begin bad++; $display("FAIL single_value: got %0h expected 55", got_q[r0]); end
      total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL single_ferr: got %0d expected 0", n_ferr - f0); end
      total++; if (RxD_busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b expected 0", RxD_busy); end
   endtask

   task automatic test_back_to_back();
      int r0, f0;
      r0 = n_ready; f0 = n_ferr;
      send_frame(8'hA3, BIT_CLKS, 1'b1);
      send_frame(8'h00, BIT_CLKS, 1'b1);
      last_good = 8'h00;
      repeat (BIT_CLKS) @(negedge clk);
      total++; if (n_ready - r0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", n_ready - r0); end
      total++; if (got_q[r0] !== 8'hA3) begin bad++; $display("FAIL b2b_first: got %0h expected a3", got_q[r0]); end
      total++; if (got_q[r0+1] !== 8'h00) begin bad++; $display("FAIL b2b_second: got %0h expected 00", got_q[r0+1]); end
      total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL b2b_ferr: got %0d expected 0", n_ferr - f0); end
   endtask

   task automatic test_glitch();
      int r0, f0;
      r0 = n_ready; f0 = n_ferr;
      RxD = 1'b0;
      @(negedge clk);
      RxD = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL glitch_ready: got %0d expected 0", n_ready - r0); end
      total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
      total++; if (RxD_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b expected 0", RxD_busy); end
   endtask

   task automatic test_break();
      int r0, f0;
      r0 = n_ready; f0 = n_ferr;
      send_frame(8'h3C, BIT_CLKS, 1'b0);
      repeat (20 * BIT_CLKS) @(negedge clk);
      total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL break_ferr: got %0d expected 1", n_ferr - f0); end
      total++; if (n_ready - r0 !== 0) begin bad++; $display("FAIL break_ready: got %0d expected 0", n_ready - r0); end
      total++; if (RxD_data !== last_good) begin bad++; $display("FAIL break_data: got %0h expected %0h", RxD_data, last_good); end
      total++; if (RxD_busy !== 1'b1) begin bad++; $display("FAIL break_busy_low: got %b expected 1", RxD_busy); end
      RxD = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      total++; if (RxD_busy !== 1'b0) begin bad++; $display("FAIL break_busy_high: got %b expected 0", RxD_busy); end
      total++; if (n_ferr - f0 !== 1 || n_ready - r0 !== 0) begin
         bad++; $display("FAIL break_after: got ferr=%0d ready=%0d expected 1 0", n_ferr - f0, n_ready - r0);
      end
   endtask

   // Random bytes, random +-1.4 % bit length, random gaps (including none)
   // and occasional bad stop bits, against a queue of expected bytes.
   task automatic test_random();
      int         r0, f0, exp_err, bc, gap;
      logic [7:0] b;
      logic       stop_v;
      logic [7:0] exp_q[$];
      r0 = n_ready; f0 = n_ferr; exp_err = 0;
      for (int k = 0; k < 5; k++) begin
         b      = 8'($urandom);
         bc     = BIT_CLKS - 6 + int'($urandom_range(0, 12));
         stop_v = ($urandom_range(0, 3) != 0);
         send_frame(b, bc, stop_v);
         RxD = 1'b1;
         if (stop_v) begin
            exp_q.push_back(b);
            last_good = b;
            gap = int'($urandom_range(0, 1));
         end else begin
            exp_err++;
            gap = 1;
         end
         repeat (gap * BIT_CLKS) @(negedge clk);
      end
      repeat (BIT_CLKS) @(negedge clk);
      total++; if (n_ready - r0 !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d expected %0d", n_ready - r0, exp_q.size()); end
      total++; if (n_ferr - f0 !== exp_err) begin bad++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr - f0, exp_err); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++; if (got_q[r0+i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %0h expected %0h", i, got_q[r0+i], exp_q[i]); end
      end
      total++; if (RxD_data !== last_good) begin bad++; $display("FAIL rand_hold: got %0h expected %0h", RxD_data, last_good); end
   endtask

   task automatic test_reset_midframe();
      int         r0;
      logic [7:0] partial;
      send_frame(8'hC5, BIT_CLKS, 1'b1);
      last_good = 8'hC5;
      repeat (BIT_CLKS) @(negedge clk);
      total++; if (RxD_data !== 8'hC5) begin bad++; $display("FAIL pre_reset_data: got %0h expected c5", RxD_data); end
      r0 = n_ready;
      partial = 8'h6E;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bit(partial[i], BIT_CLKS);
      rst_n = 1'b0;
      RxD   = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (RxD_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got %0h expected 00", RxD_data); end
      total++; if (RxD_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b expected 0", RxD_busy); end
      total++; if (RxD_data_ready !== 1'b0 || RxD_frame_err !== 1'b0) begin
         bad++; $display("FAIL mid_reset_pulses: got %b%b expected 00", RxD_data_ready, RxD_frame_err);
      end
      rst_n = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      send_frame(8'h81, BIT_CLKS, 1'b1);
      last_good = 8'h81;
      repeat (BIT_CLKS) @(negedge clk);
      total++; if (n_ready - r0 !== 1) begin bad++; $display("FAIL post_reset_count: got %0d expected 1", n_ready - r0); end
      total++; if (RxD_data !== 8'h81) begin bad++; $display("FAIL post_reset_data: got %0h expected 81", RxD_data); end
   endtask

   task automatic test_pulse_shape();
      total++; if (n_overlap !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d expected 0", n_overlap); end
      total++; if (n_wide !== 0) begin bad++; $display("FAIL pulse_width: got %0d expected 0", n_wide); end
   endtask

`ifdef ASYNC_RX_IDLE_DETECT_EN
   task automatic test_idle_detect();
      int     e0;
      longint stop_end;
      logic   in_window;
      repeat (11 * BIT_CLKS) @(negedge clk);
      e0 = n_eop;
      send_frame(8'h7E, BIT_CLKS, 1'b1);
      stop_end = cyc;
      repeat (13 * BIT_CLKS) @(negedge clk);
      in_window = (eop_cyc - stop_end >= longint'(9 * BIT_CLKS)) &&
                  (eop_cyc - stop_end <= longint'(12 * BIT_CLKS));
      total++; if (n_eop - e0 !== 1) begin bad++; $display("FAIL eop_count: got %0d expected 1", n_eop - e0); end
      total++; if (in_window !== 1'b1) begin bad++; $display("FAIL eop_timing: got %0d clks expected 3906..5208", eop_cyc - stop_end); end
      total++; if (RxD_idle !== 1'b1) begin bad++; $display("FAIL idle_level: got %b expected 1", RxD_idle); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_break();
      test_random();
      test_reset_midframe();
`ifdef ASYNC_RX_IDLE_DETECT_EN
      test_idle_detect();
`endif
      test_pulse_shape();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
